// File: rtl/jk_reg_bank.sv
// WIDTH-bit register whose bits follow JK semantics, with load, shift-left and count-up modes, plus a saturating change counter.
// One-cycle latency from inputs to q and no backpressure; define JK_PARITY_EN to add a registered parity output with an error-injection hook.
module jk_reg_bank #(
  parameter int unsigned           WIDTH     = 8,
  parameter int unsigned           CNT_W     = 8,
  parameter logic [WIDTH-1:0]      RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  input  logic [WIDTH-1:0] d,
  input  logic             sin,
  input  logic             clr_cnt,
`ifdef JK_PARITY_EN
  input  logic             par_err_inj,
  output logic             parity,
`endif
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             sout,
  output logic             carry,
  output logic [CNT_W-1:0] chg_cnt,
  output logic             chg_sat
);

  localparam logic [1:0] MODE_JK    = 2'b00;
  localparam logic [1:0] MODE_LOAD  = 2'b01;
  localparam logic [1:0] MODE_SHIFT = 2'b10;
  localparam logic [1:0] MODE_COUNT = 2'b11;

  logic [WIDTH-1:0] next_q;
  logic [WIDTH-1:0] shl_q;
  logic [WIDTH-1:0] jk_q;
  logic             carry_nxt;
  logic             changed;

  // A one-bit register has nothing to shift, so the serial input simply replaces it.
  generate
    if (WIDTH == 1) begin : g_shl_narrow
      assign shl_q = sin;
    end else begin : g_shl_wide
      assign shl_q = {q[WIDTH-2:0], sin};
    end
  endgenerate

  // Characteristic equation q+ = j&~q | ~k&q, applied to every bit at once.
  assign jk_q = (j & ~q) | (~k & q);

  always_comb begin
    next_q    = q;
    carry_nxt = 1'b0;
    if (en) begin
      case (mode)
        MODE_JK:    next_q = jk_q;
        MODE_LOAD:  next_q = d;
        MODE_SHIFT: next_q = shl_q;
        MODE_COUNT: begin
          next_q    = q + 1'b1;
          carry_nxt = &q;
        end
        default:    next_q = q;
      endcase
    end
  end

  assign changed = en & (next_q != q);
  assign chg_sat = &chg_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q     <= RESET_VAL;
      carry <= 1'b0;
    end else begin
      q     <= next_q;
      carry <= carry_nxt;
    end
  end

  // Clear wins over a simultaneous change; the count sticks at all ones.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      chg_cnt <= '0;
    end else if (clr_cnt) begin
      chg_cnt <= '0;
    end else if (changed && !chg_sat) begin
      chg_cnt <= chg_cnt + 1'b1;
    end
  end

`ifdef JK_PARITY_EN
  // Injection corrupts only the edge it is sampled on; the next edge recomputes from q.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      parity <= ^RESET_VAL;
    end else begin
      parity <= (en & par_err_inj) ? ~(^next_q) : ^next_q;
    end
  end
`endif

  assign qbar = ~q;
  assign sout = q[WIDTH-1];

endmodule

// File: tb/tb_jk_reg_bank.sv
// Directed bench for jk_reg_bank: an 8-bit counter instance and a 2-bit counter instance share one stimulus stream.
module tb_jk_reg_bank;

  logic       clk;
  logic       reset;
  logic       en;
  logic [1:0] mode;
  logic [7:0] j, k, d;
  logic       sin;
  logic       clr_cnt;

  logic [7:0] q, qbar, q2, qbar2;
  logic       sout, carry, chg_sat, sout2, carry2, chg_sat2;
  logic [7:0] chg_cnt;
  logic [1:0] chg_cnt2;
`ifdef JK_PARITY_EN
  logic       par_err_inj;
  logic       parity, parity2;
`endif

  int checks   = 0;
  int failures = 0;

  jk_reg_bank #(.WIDTH(8), .CNT_W(8), .RESET_VAL(8'h00)) u_dut (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .j(j), .k(k), .d(d),
    .sin(sin), .clr_cnt(clr_cnt),
`ifdef JK_PARITY_EN
    .par_err_inj(par_err_inj), .parity(parity),
`endif
    .q(q), .qbar(qbar), .sout(sout), .carry(carry),
    .chg_cnt(chg_cnt), .chg_sat(chg_sat)
  );

  jk_reg_bank #(.WIDTH(8), .CNT_W(2), .RESET_VAL(8'h00)) u_sat (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .j(j), .k(k), .d(d),
    .sin(sin), .clr_cnt(clr_cnt),
`ifdef JK_PARITY_EN
    .par_err_inj(par_err_inj), .parity(parity2),
`endif
    .q(q2), .qbar(qbar2), .sout(sout2), .carry(carry2),
    .chg_cnt(chg_cnt2), .chg_sat(chg_sat2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; en = 1'b0; mode = 2'b00; j = 8'h00; k = 8'h00; d = 8'h00;
    sin = 1'b0; clr_cnt = 1'b0;
`ifdef JK_PARITY_EN
    par_err_inj = 1'b0;
`endif
    #12;
    chk("rst_q", q, 8'h00);
    chk("rst_qbar", qbar, 8'hFF);
    chk("rst_cnt", chg_cnt, 8'd0);
    chk("rst_carry", carry, 1'b0);
    chk("rst_sout", sout, 1'b0);
    chk("rst_sat", chg_sat, 1'b0);
    chk("rst_sat2", chg_sat2, 1'b0);

    // JK set/clear then toggle
    reset = 1'b1; en = 1'b1; mode = 2'b00; j = 8'hF0; k = 8'h0F;
    step();
    chk("jk_setclr_q", q, 8'hF0);
    chk("jk_setclr_cnt", chg_cnt, 8'd1);
    j = 8'hFF; k = 8'hFF;
    step();
    chk("jk_toggle_q", q, 8'h0F);
    chk("jk_toggle_qbar", qbar, 8'hF0);
    chk("jk_toggle_cnt", chg_cnt, 8'd2);

    // hold with en=0, then enabled no-change
    en = 1'b0; j = 8'hFF; k = 8'h00;
    step();
    chk("hold_q", q, 8'h0F);
    chk("hold_cnt", chg_cnt, 8'd2);
    en = 1'b1; j = 8'h00; k = 8'h00;
    step();
    chk("nochg_q", q, 8'h0F);
    chk("nochg_cnt", chg_cnt, 8'd2);

    // load then shift
    mode = 2'b01; d = 8'h81;
    step();
    chk("load_q", q, 8'h81);
    chk("load_cnt", chg_cnt, 8'd3);
    chk("sout_0", sout, 1'b1);
    mode = 2'b10; sin = 1'b1;
    step();
    chk("shift1_q", q, 8'h03);
    chk("sout_1", sout, 1'b0);
    sin = 1'b0;
    step();
    chk("shift2_q", q, 8'h06);
    chk("sout_2", sout, 1'b0);
    sin = 1'b1;
    step();
    chk("shift3_q", q, 8'h0D);
    chk("shift3_cnt", chg_cnt, 8'd6);

    // count wrap
    mode = 2'b01; d = 8'hFE;
    step();
    chk("cload_q", q, 8'hFE);
    mode = 2'b11;
    step();
    chk("cnt1_q", q, 8'hFF);
    chk("cnt1_carry", carry, 1'b0);
    step();
    chk("cnt2_q", q, 8'h00);
    chk("cnt2_carry", carry, 1'b1);
    step();
    chk("cnt3_q", q, 8'h01);
    chk("cnt3_carry", carry, 1'b0);
    chk("cnt3_cnt", chg_cnt, 8'd10);

    // clear honoured while disabled
    en = 1'b0; clr_cnt = 1'b1;
    step();
    chk("clr_dis_cnt", chg_cnt, 8'd0);
    chk("clr_dis_cnt2", chg_cnt2, 2'd0);
    chk("clr_dis_q", q, 8'h01);

    // saturation on the 2-bit counter
    en = 1'b1; clr_cnt = 1'b0; mode = 2'b00; j = 8'hFF; k = 8'hFF;
    step(); step(); step();
    chk("sat3_cnt2", chg_cnt2, 2'd3);
    chk("sat3_sat2", chg_sat2, 1'b1);
    step(); step();
    chk("sat5_cnt2", chg_cnt2, 2'd3);
    chk("sat5_sat2", chg_sat2, 1'b1);
    chk("sat5_cnt", chg_cnt, 8'd5);
    chk("sat5_sat", chg_sat, 1'b0);
    chk("sat5_q", q, 8'hFE);
    clr_cnt = 1'b1;
    step();
    chk("clr_tog_q", q, 8'h01);
    chk("clr_tog_cnt2", chg_cnt2, 2'd0);
    chk("clr_tog_cnt", chg_cnt, 8'd0);
    clr_cnt = 1'b0;

    // async reset mid-count
    mode = 2'b01; d = 8'h10;
    step();
    mode = 2'b11;
    step();
    chk("pre_arst_q", q, 8'h11);
    chk("pre_arst_cnt", chg_cnt, 8'd2);
    #3 reset = 1'b0;
    #1;
    chk("arst_q", q, 8'h00);
    chk("arst_carry", carry, 1'b0);
    chk("arst_cnt", chg_cnt, 8'd0);
    chk("arst_qbar", qbar, 8'hFF);
    #2 reset = 1'b1;
    step();
    chk("resume1_q", q, 8'h01);
    chk("resume1_cnt", chg_cnt, 8'd1);
    step();
    chk("resume2_q", q, 8'h02);

`ifdef JK_PARITY_EN
    chk("par_q02", parity, 1'b1);
    mode = 2'b01; d = 8'h03; par_err_inj = 1'b1;
    step();
    chk("par_inj", parity, 1'b1);
    par_err_inj = 1'b0; en = 1'b0;
    step();
    chk("par_recover", parity, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/jk_reg_bank.md
Name: jk_reg_bank

Overview:
- Parametrised, multi-bit successor to the single JK flip-flop.
- Holds a WIDTH-bit register whose bits each obey JK semantics. Also supports parallel load, serial shift-left and synchronous up-count modes.
- Tracks how many enabled cycles changed the register contents, using a saturating change counter.
- Used as a general control/status register primitive in lab datapaths.

Parameters:
- WIDTH, 8, register width in bits (>=1)
- CNT_W, 8, change-counter width in bits (>=1)
- RESET_VAL, {WIDTH{1'b0}}, value loaded into q on reset

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous active-low reset
- en  input  1  operation enable; 0 = hold everything
- mode  input  2  00 JK, 01 load, 10 shift-left, 11 count-up
- j  input  WIDTH  per-bit J inputs (mode 00)
- k  input  WIDTH  per-bit K inputs (mode 00)
- d  input  WIDTH  parallel load data (mode 01)
- sin  input  1  serial input into bit 0 (mode 10)
- clr_cnt  input  1  synchronous clear of change counter
- q  output  WIDTH  register state
- qbar  output  WIDTH  ~q, combinational
- sout  output  1  q[WIDTH-1], combinational
- carry  output  1  registered one-cycle wrap pulse (mode 11)
- chg_cnt  output  CNT_W  count of enabled cycles in which q changed
- chg_sat  output  1  chg_cnt == all ones, combinational

Behaviour:
- Reset (reset=0, asynchronous, immediate, overrides all inputs, including mid-operation):
  - q=RESET_VAL, carry=0, chg_cnt=0.
  - Consequently qbar=~RESET_VAL, sout=RESET_VAL[WIDTH-1], chg_sat=0.
- All state updates on rising clk edge when reset=1. Latency: one cycle from inputs to q.
- en=0:
  - q held, carry<=0.
  - chg_cnt is not incremented; clr_cnt is still honoured.
- en=1, mode 00: per bit i, {j[i],k[i]}:
  - 00 hold, 01 clear, 10 set, 11 toggle.
  - All bits are evaluated independently in the same cycle.
- en=1, mode 01: q<=d.
- en=1, mode 10: q<={q[WIDTH-2:0],sin}.
  - For WIDTH=1, q<=sin.
  - The bit shifted out is visible on sout before the edge.
- en=1, mode 11: q<=q+1 modulo 2^WIDTH.
  - carry<=1 for exactly one cycle when q was all ones before the edge; otherwise carry<=0.
- carry<=0 in every mode other than 11, and whenever en=0.
- Change counter:
  - Define next_q as the value q takes at the edge. changed = en & (next_q != q).
  - Priority: clr_cnt=1 -> chg_cnt<=0 (takes priority over a simultaneous change); else changed and not saturated -> chg_cnt<=chg_cnt+1; else hold.
  - The counter saturates at 2^CNT_W-1 and never wraps.
- Switching mode between consecutive cycles is legal. Each edge uses only that cycle's mode; no state is carried between modes.
- No X propagation: an undefined mode cannot occur because all four codes are decoded.

Optional Feature:
- Macro JK_PARITY_EN.
- When defined:
  - Adds output port parity (1 bit), registered, equal to ^q of the current register value.
  - parity updates on the same edge as q and resets to ^RESET_VAL.
  - Adds input port par_err_inj (1 bit). When par_err_inj=1 at an enabled edge, parity<=~(^next_q) for that cycle only, as a checker test hook.
- When undefined: neither port exists and no parity logic is synthesised; all other behaviour is identical.

Test Plan:
- Reset then JK, WIDTH=8:
  - reset=0 -> q=8'h00, qbar=8'hFF, chg_cnt=0.
  - Release reset; en=1, mode=00, j=8'hF0, k=8'h0F -> q=8'hF0.
  - Next cycle j=k=8'hFF -> q=8'h0F; chg_cnt=2.
- Hold and no-change:
  - en=0 with j=8'hFF -> q unchanged, chg_cnt unchanged.
  - en=1, mode=00, j=k=0 -> q unchanged, chg_cnt unchanged.
- Shift:
  - Load d=8'h81 (mode 01), then 3 cycles mode 10 with sin=1,0,1.
  - q sequence 8'h81 -> 8'h03 -> 8'h06 -> 8'h0D; sout=1,0,0 across those cycles.
- Count wrap:
  - Load 8'hFE, mode 11 for 3 cycles -> q=8'hFF, 8'h00, 8'h01.
  - carry=1 only in the cycle q=8'h00.
- Counter saturation/clear, CNT_W=2:
  - 5 toggling cycles -> chg_cnt=3, chg_sat=1, held.
  - clr_cnt=1 asserted in the same cycle as a toggle -> chg_cnt=0.
- Async reset mid-count:
  - mode 11 from 8'h10; assert reset=0 between clock edges -> q=RESET_VAL immediately, carry=0, chg_cnt=0.
  - After release, counting resumes from RESET_VAL.
